// File: rtl/miriscv_uart_pkg.sv
// Shared UART definitions for the MIRISCV receiver and the future transmitter.
package miriscv_uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/miriscv_uart_rx_fifo.sv
// Synchronous show-ahead FIFO holding received bytes; head is visible while valid_o is set.
module miriscv_uart_rx_fifo
    import miriscv_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] data_i,
    input  logic                   pop_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    output logic                   full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            count;
    logic                   push_ok_c;
    logic                   pop_ok_c;

    assign valid_o   = (count != '0);
    assign full_o    = (count == (AW+1)'(DEPTH));
    assign data_o    = mem[rd_ptr];
    // A pop in the same cycle frees the slot, so push while full is accepted then.
    assign push_ok_c = push_i && (!full_o || pop_i);
    assign pop_ok_c  = pop_i && valid_o;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/miriscv_uart_rx.sv
// MIRISCV UART receiver: 8E1 frames to a valid/ready byte stream with error pulses.
// Define MIRISCV_UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO.
module miriscv_uart_rx
    import miriscv_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUDRATE    = 6250000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   uart_rx_i,
    output logic [UART_DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   overrun_o
);

    localparam int unsigned BIT_DIV = CLK_FREQ_HZ / BAUDRATE;
    localparam int unsigned TIMER_W = $clog2(BIT_DIV);
    localparam int unsigned IDX_W   = $clog2(UART_DATA_W);

    if (BIT_DIV < 4) begin : g_bad_bit_div
        $error("miriscv_uart_rx: BIT_DIV must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("miriscv_uart_rx: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic                   rx_meta;
    logic                   rxs;
    uart_rx_state_t         state;
    uart_rx_state_t         state_nxt;
    logic [TIMER_W-1:0]     timer;
    logic [TIMER_W-1:0]     timer_nxt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] shift_nxt;
    logic                   par_bit;
    logic                   par_bit_nxt;
    logic                   push_c;
    logic                   parity_err_c;
    logic                   frame_err_c;
    logic                   half_c;
    logic                   full_c;

    assign half_c = (timer == TIMER_W'(BIT_DIV/2 - 1));
    assign full_c = (timer == TIMER_W'(BIT_DIV - 1));

    // Two-flop synchroniser; line idles high.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer + 1'b1;
        idx_nxt      = idx;
        shift_nxt    = shift;
        par_bit_nxt  = par_bit;
        push_c       = 1'b0;
        parity_err_c = 1'b0;
        frame_err_c  = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                idx_nxt   = '0;
                if (!rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_c) begin
                    timer_nxt = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_c) begin
                    timer_nxt      = '0;
                    shift_nxt[idx] = rxs;
                    idx_nxt        = idx + 1'b1;
                    if (idx == IDX_W'(UART_DATA_W - 1)) begin
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (full_c) begin
                    timer_nxt   = '0;
                    par_bit_nxt = rxs;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a following start bit be seen with no dead time.
                if (full_c) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                    if (!rxs) begin
                        frame_err_c = 1'b1;
                        state_nxt   = BREAK;
                    end else if (par_bit != uart_parity(shift)) begin
                        parity_err_c = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end
            BREAK: begin
                timer_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            timer        <= '0;
            idx          <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            timer        <= timer_nxt;
            idx          <= idx_nxt;
            shift        <= shift_nxt;
            par_bit      <= par_bit_nxt;
            parity_err_o <= parity_err_c;
            frame_err_o  <= frame_err_c;
        end
    end

`ifdef MIRISCV_UART_RX_FIFO_EN
    logic pop_c;
    logic fifo_full;

    assign pop_c = rx_valid_o && rx_ready_i;

    miriscv_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (push_c),
        .data_i  (shift),
        .pop_i   (pop_c),
        .data_o  (rx_data_o),
        .valid_o (rx_valid_o),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= push_c && fifo_full && !pop_c;
        end
    end
`else
    // Single holding register; a byte arriving while it is full and not drained is dropped.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (push_c) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= shift;
                    rx_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_miriscv_uart_rx.sv
// Directed self-checking bench for miriscv_uart_rx at default parameters (16 clocks per bit).
module tb_miriscv_uart_rx;

    localparam int BIT = 16;

    logic       clk_i;
    logic       arstn_i;
    logic       uart_rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;

    int n_cmp;
    int n_bad;
    int n_perr;
    int n_ferr;
    int n_ovr;
    int n_vcyc;
    logic [7:0] got [$];

    miriscv_uart_rx dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .uart_rx_i    (uart_rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Event recorder, sampled on the falling edge between driving instants.
    always @(negedge clk_i) begin
        if (arstn_i) begin
            if (parity_err_o) n_perr++;
            if (frame_err_o) n_ferr++;
            if (overrun_o) n_ovr++;
            if (rx_valid_o) n_vcyc++;
            if (rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_mon();
        n_perr = 0;
        n_ferr = 0;
        n_ovr  = 0;
        n_vcyc = 0;
        got.delete();
    endtask

    task automatic send_bit(input logic v);
        uart_rx_i = v;
        tick(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        uart_rx_i = 1'b1;
        tick(n * BIT);
    endtask

    task automatic test_reset();
        arstn_i    = 1'b0;
        uart_rx_i  = 1'b1;
        rx_ready_i = 1'b0;
        tick(5);
        n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
        n_cmp++; if (parity_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b want 0", parity_err_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        arstn_i = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        logic [7:0] b;
        rx_ready_i = 1'b1;
        clear_mon();
        send_frame(8'h0A, 1'b0, 1'b1);
        idle_bits(2);
        b = (got.size() > 0) ? got[0] : 8'hxx;
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", got.size()); end
        n_cmp++; if (b !== 8'h0A) begin n_bad++; $display("FAIL basic_data: got %h want 0a", b); end
        n_cmp++; if (n_vcyc !== 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", n_vcyc); end
        n_cmp++; if (n_perr + n_ferr + n_ovr !== 0) begin n_bad++; $display("FAIL basic_errors: got %0d want 0", n_perr + n_ferr + n_ovr); end
    endtask

    task automatic test_back_to_back_ready();
        logic [7:0] b0;
        logic [7:0] b1;
        rx_ready_i = 1'b1;
        clear_mon();
        send_frame(8'hC3, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        idle_bits(2);
        b0 = (got.size() > 0) ? got[0] : 8'hxx;
        b1 = (got.size() > 1) ? got[1] : 8'hxx;
        n_cmp++; if (got.size() !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", got.size()); end
        n_cmp++; if (b0 !== 8'hC3) begin n_bad++; $display("FAIL b2b_first: got %h want c3", b0); end
        n_cmp++; if (b1 !== 8'h80) begin n_bad++; $display("FAIL b2b_second: got %h want 80", b1); end
        n_cmp++; if (n_perr + n_ferr + n_ovr !== 0) begin n_bad++; $display("FAIL b2b_errors: got %0d want 0", n_perr + n_ferr + n_ovr); end
    endtask

    task automatic test_parity();
        rx_ready_i = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_bits(2);
        n_cmp++; if (n_perr !== 1) begin n_bad++; $display("FAIL parity_pulses: got %0d want 1", n_perr); end
        n_cmp++; if (n_vcyc !== 0) begin n_bad++; $display("FAIL parity_valid: got %0d want 0", n_vcyc); end
        n_cmp++; if (n_ferr !== 0) begin n_bad++; $display("FAIL parity_ferr: got %0d want 0", n_ferr); end
    endtask

    task automatic test_break();
        logic [7:0] b;
        rx_ready_i = 1'b1;
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0);
        uart_rx_i = 1'b0;
        tick(30 * BIT);
        n_cmp++; if (n_ferr !== 1) begin n_bad++; $display("FAIL break_ferr: got %0d want 1", n_ferr); end
        n_cmp++; if (n_perr !== 0) begin n_bad++; $display("FAIL break_perr: got %0d want 0", n_perr); end
        n_cmp++; if (n_vcyc !== 0) begin n_bad++; $display("FAIL break_valid: got %0d want 0", n_vcyc); end
        idle_bits(2);
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(2);
        b = (got.size() > 0) ? got[0] : 8'hxx;
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL break_after_count: got %0d want 1", got.size()); end
        n_cmp++; if (b !== 8'h55) begin n_bad++; $display("FAIL break_after_data: got %h want 55", b); end
        n_cmp++; if (n_ferr !== 1) begin n_bad++; $display("FAIL break_after_ferr: got %0d want 1", n_ferr); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        rx_ready_i = 1'b0;
        clear_mon();
`ifdef MIRISCV_UART_RX_FIFO_EN
        send_frame(8'h41, 1'b0, 1'b1);
        send_frame(8'h42, 1'b0, 1'b1);
        send_frame(8'h43, 1'b1, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        idle_bits(1);
        n_cmp++; if (n_ovr !== 0) begin n_bad++; $display("FAIL fifo_no_ovr: got %0d want 0", n_ovr); end
        n_cmp++; if (rx_data_o !== 8'h41) begin n_bad++; $display("FAIL fifo_head: got %h want 41", rx_data_o); end
        send_frame(8'h45, 1'b1, 1'b1);
        idle_bits(1);
        n_cmp++; if (n_ovr !== 1) begin n_bad++; $display("FAIL fifo_ovr: got %0d want 1", n_ovr); end
        rx_ready_i = 1'b1;
        tick(6);
        rx_ready_i = 1'b0;
        tick(2);
        n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL fifo_drain_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            b = (got.size() > i) ? got[i] : 8'hxx;
            n_cmp++; if (b !== 8'(8'h41 + i)) begin n_bad++; $display("FAIL fifo_order[%0d]: got %h want %h", i, b, 8'(8'h41 + i)); end
        end
`else
        send_frame(8'h41, 1'b0, 1'b1);
        send_frame(8'h42, 1'b0, 1'b1);
        idle_bits(1);
        n_cmp++; if (n_ovr !== 1) begin n_bad++; $display("FAIL hold_ovr: got %0d want 1", n_ovr); end
        n_cmp++; if (rx_data_o !== 8'h41) begin n_bad++; $display("FAIL hold_data: got %h want 41", rx_data_o); end
        n_cmp++; if (rx_valid_o !== 1'b1) begin n_bad++; $display("FAIL hold_valid: got %b want 1", rx_valid_o); end
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
        tick(2);
        b = (got.size() > 0) ? got[0] : 8'hxx;
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL hold_drain_count: got %0d want 1", got.size()); end
        n_cmp++; if (b !== 8'h41) begin n_bad++; $display("FAIL hold_drain_data: got %h want 41", b); end
`endif
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL ovr_empty_after: got %b want 0", rx_valid_o); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        rx_ready_i = 1'b1;
        clear_mon();
        uart_rx_i = 1'b0;
        tick(3);
        idle_bits(3);
        n_cmp++; if (n_vcyc !== 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", n_vcyc); end
        n_cmp++; if (n_perr + n_ferr + n_ovr !== 0) begin n_bad++; $display("FAIL glitch_errors: got %0d want 0", n_perr + n_ferr + n_ovr); end
        send_frame(8'h96, 1'b0, 1'b1);
        idle_bits(2);
        b = (got.size() > 0) ? got[0] : 8'hxx;
        n_cmp++; if (b !== 8'h96) begin n_bad++; $display("FAIL glitch_next_data: got %h want 96", b); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        rx_ready_i = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b0, 1'b1);
        idle_bits(1);
        n_cmp++; if (rx_valid_o !== 1'b1) begin n_bad++; $display("FAIL rmid_stored: got %b want 1", rx_valid_o); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        arstn_i = 1'b0;
        tick(2);
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", rx_valid_o); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL rmid_data: got %h want 00", rx_data_o); end
        n_cmp++; if ({parity_err_o, frame_err_o, overrun_o} !== 3'b000) begin n_bad++; $display("FAIL rmid_errs: got %b want 000", {parity_err_o, frame_err_o, overrun_o}); end
        uart_rx_i = 1'b1;
        tick(2);
        arstn_i = 1'b1;
        idle_bits(2);
        rx_ready_i = 1'b1;
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_bits(2);
        b = (got.size() > 0) ? got[0] : 8'hxx;
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL rmid_count: got %0d want 1", got.size()); end
        n_cmp++; if (b !== 8'h3C) begin n_bad++; $display("FAIL rmid_next_data: got %h want 3c", b); end
        n_cmp++; if (n_perr + n_ferr + n_ovr !== 0) begin n_bad++; $display("FAIL rmid_next_errors: got %0d want 0", n_perr + n_ferr + n_ovr); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        arstn_i    = 1'b0;
        uart_rx_i  = 1'b1;
        rx_ready_i = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_back_to_back_ready();
        test_parity();
        test_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
